// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with mid-bit sampling, stop-bit check and break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parityErr output.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frameErr,
`ifdef UART_RX_PARITY_EN
    output logic                 parityErr,
`endif
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t               r_state;
    logic                 r_s1;
    logic                 r_s2;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_sh;
    logic                 w_tick_last;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err;
`endif
    assign w_tick_last = r_tick == T_LAST;
    assign busy        = r_state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_state  <= IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            data     <= '0;
            valid    <= 1'b0;
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            r_s1     <= in;
            r_s2     <= r_s1;
            valid    <= 1'b0;
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_tick <= '0;
                    if (!r_s2) r_state <= START;
                end
                START: begin
                    // a start bit must still be low at its centre, otherwise it was a glitch
                    if (r_tick == T_MID) begin
                        r_state <= r_s2 ? IDLE : DATA;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick_last) begin
                        for (int k = 0; k < DATA_BITS - 1; k++) r_sh[k] <= r_sh[k+1];
                        r_sh[DATA_BITS-1] <= r_s2;
                        r_bit  <= r_bit + 1'b1;
                        r_tick <= '0;
                        if (r_bit == B_LAST) r_state <= AFTER_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick_last) begin
                        r_par_err <= r_s2 != ^r_sh;
                        r_tick    <= '0;
                        r_state   <= STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // leave at mid-stop so a start edge right at the bit boundary is caught
                    if (w_tick_last) begin
                        data     <= r_sh;
                        valid    <= 1'b1;
                        frameErr <= !r_s2;
`ifdef UART_RX_PARITY_EN
                        parityErr <= r_par_err;
`endif
                        r_tick   <= '0;
                        r_state  <= r_s2 ? IDLE : BREAK;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                BREAK: begin
                    if (r_s2) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level scoreboard for uart_rx; expected strobes come from bit-period
// arithmetic on the frames sent, plus directed glitch, break and mid-frame reset sequences.
module tb_uart_rx;
    localparam int OS = 16;
    localparam int DB = 8;
    localparam int M  = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DB + 2;
`else
    localparam int NB = DB + 1;
`endif
    localparam int LAT = 2 + M + NB * OS;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         gap;
        logic       fe;
        logic       pe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       line;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   ev;
    exp_t q[$];
    vec_t vecs[6];

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (line),
        .data     (data),
        .valid    (valid),
        .frameErr (frame_err),
`ifdef UART_RX_PARITY_EN
        .parityErr(parity_err),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a falling edge; the start bit is seen by the next rising edge (t0 = cyc+1).
    task automatic send(input logic [7:0] d, input logic stop, input logic par, input bit track,
                        input logic efe, input logic epe);
        if (track) q.push_back('{d: d, fe: efe, pe: epe, cyc: cyc + 1 + LAT});
        line = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            line = d[i];
            repeat (OS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        line = par;
        repeat (OS) @(negedge clk);
`endif
        line = stop;
        repeat (OS) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev = q.size() > 0 && q[0].cyc == cyc;
        if (valid || ev) begin
            chk("valid", 32'(valid), 32'(ev));
            if (valid && ev) begin
                chk("data", 32'(data), 32'(q[0].d));
                chk("frameErr", 32'(frame_err), 32'(q[0].fe));
`ifdef UART_RX_PARITY_EN
                chk("parityErr", 32'(parity_err), 32'(q[0].pe));
`endif
            end
            if (ev) void'(q.pop_front());
        end else begin
            chk("frameErr_quiet", 32'(frame_err), 32'(0));
`ifdef UART_RX_PARITY_EN
            chk("parityErr_quiet", 32'(parity_err), 32'(0));
`endif
        end
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         c;
        vecs = '{
            '{8'h00, 1'b1, 1'b0, 0,  1'b0, 1'b0},
            '{8'hFF, 1'b1, 1'b0, 25, 1'b0, 1'b0},
            '{8'h07, 1'b1, 1'b1, 12, 1'b0, 1'b0},
            '{8'h07, 1'b1, 1'b0, 12, 1'b0, 1'b1},
            '{8'h5A, 1'b0, 1'b0, 40, 1'b1, 1'b0},
            '{8'hC3, 1'b1, 1'b0, 8,  1'b0, 1'b0}
        };
        reset = 1'b1;
        line  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        // 0xA5 with busy window around the start edge and the strobe
        fork
            send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                chk("busy_t1", 32'(busy), 32'(0));
                @(negedge clk);
                chk("busy_t2", 32'(busy), 32'(1));
                repeat (151) @(negedge clk);
                chk("busy_t153", 32'(busy), 32'(1));
                repeat (2) @(negedge clk);
                chk("busy_t155", 32'(busy), 32'(0));
            end
        join
        line = 1'b1;
        repeat (20) @(negedge clk);
        // 4-cycle low glitch: start detected, rejected at the mid-start check
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        chk("glitch_busy", 32'(busy), 32'(1));
        repeat (8) @(negedge clk);
        chk("glitch_idle", 32'(busy), 32'(0));
        repeat (200) @(negedge clk);
        chk("glitch_data", 32'(data), 32'(8'hA5));
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].stop, vecs[i].par, 1'b1, vecs[i].fe, vecs[i].pe);
            line = 1'b1;
            repeat (vecs[i].gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        // break: stop bit low then line held low, one frameErr strobe only
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        chk("break_busy", 32'(busy), 32'(1));
        line = 1'b1;
        repeat (2) @(negedge clk);
        chk("break_hold", 32'(busy), 32'(1));
        @(negedge clk);
        chk("break_exit", 32'(busy), 32'(0));
        repeat (OS) @(negedge clk);
        send(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        line = 1'b1;
        repeat (20) @(negedge clk);
        // reset during the last data bit, late enough that the tail cannot pass as a start bit
        fork
            send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (136) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("mid_rst_data", 32'(data), 32'(0));
                chk("mid_rst_valid", 32'(valid), 32'(0));
                chk("mid_rst_busy", 32'(busy), 32'(0));
            end
        join
        line = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            d    = 8'($urandom);
            stop = $urandom_range(0, 7) != 0;
            par  = 1'($urandom);
            send(d, stop, par, 1'b1, !stop, par ^ (^d));
            if (!stop) begin
                repeat ($urandom_range(0, 50)) @(negedge clk);
                line = 1'b1;
                repeat (OS) @(negedge clk);
            end
            line = 1'b1;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        line = 1'b1;
        repeat (LAT + OS) @(negedge clk);
        c = q.size();
        chk("drained", 32'(c), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
